// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: sequencer states, sizing constants and
// two's-complement helpers used by the divider (and later the sequential
// Booth multiplier).
package arith_pkg;

   // Sequencer states for multi-cycle arithmetic operations.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Default datapath width and its step-counter width.
   localparam int ARITH_WIDTH = 32;
   localparam int ARITH_CNT_W = $clog2(ARITH_WIDTH);

   // Helpers operate on a 64-bit carrier; callers zero-extend their operand
   // into it and truncate the result back, which is exact modulo 2^WIDTH
   // for any WIDTH up to 64.
   localparam int ARITH_MAX_W = 64;
   typedef logic [ARITH_MAX_W-1:0] word_t;

   // Two's-complement negation.
   function automatic word_t neg(input word_t x);
      return ~x + word_t'(1);
   endfunction

   // Magnitude of a w-bit value: negated only when signed and negative.
   function automatic word_t abs_val(input word_t x, input logic signed_op, input int w);
      return (signed_op && x[w-1]) ? neg(x) : x;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one, try
// subtracting the divisor magnitude, keep the difference if it is not
// negative and record the outcome as the new quotient LSB.
module div_restore_step
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor_mag,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   // Partial remainder after the shift; one extra bit because the shifted
   // value can reach 2*divisor_mag-1, which may exceed WIDTH bits.
   logic [WIDTH:0] rem_sh;
   logic           fits;

   // Trial subtraction; "trial >= 0" is the unsigned compare rem_sh >= divisor.
   always_comb begin
      // NOTE: every always_comb output gets a default first so that no path
      // leaves it unassigned, which would otherwise infer a latch.
      rem_sh   = '0;
      fits     = 1'b0;
      rem_next = '0;
      quo_next = '0;

      rem_sh = {rem, quo[WIDTH-1]};
      fits   = (rem_sh >= {1'b0, divisor_mag});
      if (fits) begin
         // When the divisor fits, the difference is below divisor_mag and
         // therefore fits back into WIDTH bits.
         rem_next = WIDTH'(rem_sh - {1'b0, divisor_mag});
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_sh[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_booth_divider.sv
// Multi-cycle signed/unsigned integer divider. Divides magnitudes with one
// restoring step per cycle, then applies signs in a fix-up cycle. Follows
// the Booth multiplier's overflow convention for MIN / -1.
// WIDTH must be even, >= 4 and <= 64.
module seq_booth_divider
   import arith_pkg::*;
#(
   parameter int WIDTH = ARITH_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int             CNT_W   = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [CNT_W-1:0] step_cnt;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dmag_q;
   logic             q_neg;
   logic             r_neg;
   logic             ovf_pend;

   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH-1:0] quo_signed;
   logic [WIDTH-1:0] rem_signed;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;

   // Operand magnitudes at acceptance and signed results for the fix-up cycle.
   always_comb begin
      dividend_mag = WIDTH'(abs_val(word_t'(dividend), signed_op, WIDTH));
      divisor_mag  = WIDTH'(abs_val(word_t'(divisor), signed_op, WIDTH));
      quo_signed   = q_neg ? WIDTH'(neg(word_t'(quo_q))) : quo_q;
      rem_signed   = r_neg ? WIDTH'(neg(word_t'(rem_q))) : rem_q;
   end

   // Single restoring step, reused on every CALC cycle.
   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem         (rem_q),
      .quo         (quo_q),
      .divisor_mag (dmag_q),
      .rem_next    (step_rem),
      .quo_next    (step_quo)
   );

   // Sequencer with registered handshake and result outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      if (!rst_n) begin
         state       <= IDLE;
         step_cnt    <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dmag_q      <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         ovf_pend    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // The quotient register starts as the dividend magnitude and
                  // is shifted out into the remainder one bit per step.
                  rem_q       <= '0;
                  quo_q       <= dividend_mag;
                  dmag_q      <= divisor_mag;
                  q_neg       <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg       <= signed_op & dividend[WIDTH-1];
                  ovf_pend    <= signed_op & (dividend == MIN_VAL) & (divisor == '1);
                  step_cnt    <= CNT_W'(WIDTH - 1);
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end

            CALC: begin
               rem_q    <= step_rem;
               quo_q    <= step_quo;
               step_cnt <= step_cnt - 1'b1;
               if (step_cnt == '0) begin
                  state <= FIX;
               end
            end

            FIX: begin
               overflow <= ovf_pend;
               if (ovf_pend) begin
                  quotient  <= MIN_VAL;
                  remainder <= '0;
               end else begin
                  quotient  <= quo_signed;
                  remainder <= rem_signed;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= DONE;
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_booth_divider.sv
// Scoreboard bench for seq_booth_divider (WIDTH=32): directed vectors push
// hand-computed results into a queue; a monitor pops and compares on done.
module tb_seq_booth_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        signed_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;
   logic        overflow;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
      int          done_cyc;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   seq_booth_divider #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Cycle index: value k means edge k has just occurred.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares every done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".quotient"}, quotient, e.q);
            check({e.name, ".remainder"}, remainder, e.r);
            check({e.name, ".div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
            check({e.name, ".overflow"}, 32'(overflow), 32'(e.ovf));
            check({e.name, ".busy_at_done"}, 32'(busy), 32'd0);
            // done is first sampled high at the next rising edge.
            check({e.name, ".latency"}, 32'(cyc + 1), 32'(e.done_cyc));
         end
      end
   end

   // Drive one request (called at posedge+1), record the acceptance edge,
   // push the expectation, then scramble the inputs.
   task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input logic eovf, input int lat, input string name);
      exp_t e;
      signed_op = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      e.q        = eq;
      e.r        = er;
      e.dbz      = edbz;
      e.ovf      = eovf;
      e.done_cyc = cyc + lat;
      e.name     = name;
      sb.push_back(e);
      signed_op = ~sgn;
      dividend  = ~a;
      divisor   = 32'h3;
   endtask

   // Wait (bounded) for done; optionally hold a junk start through the DONE
   // cycle. Returns at posedge+1 in the IDLE cycle right after DONE.
   task automatic wait_done(input bit junk);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 100);
      if (done !== 1'b1) check("done_timeout", 32'(done), 32'd1);
      if (junk) begin
         start     = 1'b1;
         signed_op = 1'b0;
         dividend  = 32'h0000_0055;
         divisor   = 32'h0000_0001;
      end
      @(posedge clk);
      #1;
   endtask

   // Pulse start with unrelated operands so that it is sampled at edge c.
   task automatic stray_start(input int c);
      while (cyc < c - 1) begin
         @(posedge clk);
         #1;
      end
      check("busy_during_calc", 32'(busy), 32'd1);
      signed_op = 1'b0;
      dividend  = 32'd50;
      divisor   = 32'd5;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      int t0;
      rst_n     = 1'b0;
      start     = 1'b0;
      signed_op = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.busy", 32'(busy), 32'd0);
      check("reset.done", 32'(done), 32'd0);
      check("reset.quotient", quotient, 32'd0);
      check("reset.remainder", remainder, 32'd0);
      check("reset.flags", {30'd0, div_by_zero, overflow}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Signed 100/7 with stray starts at +5 and +20 that must be ignored.
      issue(1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34, "s_100_7");
      t0 = cyc;
      stray_start(t0 + 5);
      stray_start(t0 + 20);
      wait_done(1'b0);

      issue(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 34, "s_m100_7");
      wait_done(1'b0);
      issue(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 34, "s_100_m7");
      wait_done(1'b0);
      issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 34, "s_m100_m7");
      wait_done(1'b0);
      issue(1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 34, "u_max_2");
      wait_done(1'b0);
      issue(1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 34, "s_m1_2");
      wait_done(1'b0);
      issue(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1, "u_div0");
      wait_done(1'b0);
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 34, "s_min_m1");
      wait_done(1'b0);
      issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 34, "u_min_max");
      wait_done(1'b0);
      issue(1'b1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1, "s_div0");
      wait_done(1'b0);
      issue(1'b1, 32'hFFFF_FFF9, 32'd100, 32'd0, 32'hFFFF_FFF9, 1'b0, 1'b0, 34, "s_m7_100");
      // Junk start held through DONE must be ignored; next start accepted.
      wait_done(1'b1);
      issue(1'b0, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 34, "u_b2b_div1");
      wait_done(1'b0);

      // Reset sampled at edge +10 of a division aborts it without done.
      signed_op = 1'b0;
      dividend  = 32'd1000;
      divisor   = 32'd3;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0    = cyc;
      while (cyc < t0 + 9) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.quotient", quotient, 32'd0);
      check("abort.remainder", remainder, 32'd0);
      check("abort.flags", {30'd0, div_by_zero, overflow}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0, 34, "u_after_abort");
      wait_done(1'b0);

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seq_booth_divider.md
Name: seq_booth_divider

Overview:
- Multi-cycle integer divider; the inverse of the team's combinational 32x32 radix-4 Booth multiplier.
- Computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, using radix-2 restoring division on magnitudes, one quotient bit per cycle.
- Sits beside the multiplier in the arithmetic unit and shares its overflow convention.
- A start/done handshake lets a controller issue one division at a time.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >= 4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- signed_op  input  1  1: operands two's complement; 0: unsigned. Sampled with start.
- dividend  input  WIDTH  sampled with start.
- divisor  input  WIDTH  sampled with start.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  single-cycle pulse; results valid from this cycle.
- quotient  output  WIDTH  result; held until the next accepted start.
- remainder  output  WIDTH  result; sign follows dividend in signed mode.
- div_by_zero  output  1  divisor was 0; held with results.
- overflow  output  1  signed most-negative / -1; held with results.

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state IDLE; busy, done, div_by_zero, overflow = 0; quotient, remainder = 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge T:
  - Latch magnitudes: |x| in signed mode, raw value in unsigned mode.
  - Latch q_neg = signed_op & (dividend[MSB]^divisor[MSB]) and r_neg = signed_op & dividend[MSB].
  - Clear div_by_zero and overflow; load step counter = WIDTH-1.
  - If divisor==0: go to DONE, else CALC. busy=1 from T+1.
- CALC, each cycle:
  - {rem,quo} shifted left 1.
  - trial = rem - divisor_mag, computed in WIDTH+1 bits.
  - If trial >= 0: rem = trial and quo LSB = 1, else quo LSB = 0.
  - Counter decrements; after the WIDTH-th step go to FIX. Exactly WIDTH cycles.
- FIX, one cycle:
  - quotient = q_neg ? -quo : quo; remainder = r_neg ? -rem : rem (mod 2^WIDTH).
  - overflow = signed_op & dividend==MIN & divisor==all-ones; quotient = MIN (0x80000000), remainder = 0.
  - Go to DONE.
- DONE, one cycle:
  - done=1, busy=0; return to IDLE.
  - Divide-by-zero path: quotient = all-ones, remainder = original dividend, div_by_zero=1.
- Latency: normal start at T gives done at T+WIDTH+2 (T+34 for WIDTH=32). Divide-by-zero gives done at T+1.
- start while busy=1, or in DONE: ignored, not queued. start in the IDLE cycle right after DONE is accepted.
- Inputs may change freely after acceptance; only the latched copies are used.
- Outputs other than done/busy update only in FIX or on the DONE entry for divide-by-zero; otherwise they hold.
- Identity: dividend = quotient*divisor + remainder (mod 2^WIDTH), with |remainder| < |divisor|, whenever div_by_zero=0.

Decomposition:
- Shared package arith_pkg:
  - state enum (IDLE, CALC, FIX, DONE).
  - localparam for counter width, clog2(WIDTH).
  - functions abs_val(x, signed_op) and neg(x).
  - Reusable by the Booth multiplier's future sequential variant.
- One sub-module, div_restore_step: combinational single restoring step. Inputs {rem, quo, divisor_mag}; outputs next {rem, quo}. Instantiated once, reused every CALC cycle.

Test Plan:
- Signed 100 / 7 -> quotient 14, remainder 2, done exactly 34 cycles after start, flags 0.
- Signed -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. Signed 100 / -7 -> 0xFFFFFFF2, remainder 2.
- Unsigned 0xFFFFFFFF / 2 -> quotient 0x7FFFFFFF, remainder 1. The same operands signed (-1/2) -> quotient 0, remainder 0xFFFFFFFF.
- Divisor 0, dividend 0x12345678 -> done 1 cycle later, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero=1. Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow=1.
- start pulsed at cycles +5 and +20 during busy with other operands -> ignored, first result unchanged. Back-to-back start in the cycle after done -> accepted.
- rst_n=0 at cycle +10 of a division -> next cycle busy=0, outputs 0, no done pulse. A new start then completes normally.
